// File: rtl/sumnb_serial.sv
// sumnb_serial: digit-serial adder (optional subtractor). It adds DIGIT bits per
// clock, least significant digit first, and keeps the carry in a register.
// Optional feature macro: SUM_SUB_EN. When it is defined, the op port exists and
// op = 1 selects subtract (A - B - Ci, Co = borrow-out).
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rst   - synchronous reset, active-high
//   start - request; sampled only in IDLE or DONE
//   A, B  - WIDTH-bit operands, captured on an accepted start
//   Ci    - carry-in (borrow-in when subtracting), captured on an accepted start
//   op    - (SUM_SUB_EN only) 0 = add, 1 = subtract, captured on an accepted start
//   busy  - high while the operation is in RUN
//   done  - one-cycle pulse; S/Co are valid from this cycle until the next accept
//   S     - WIDTH-bit result
//   Co    - carry-out (borrow-out in subtract mode)
module sumnb_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
`ifdef SUM_SUB_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N + 1 > 1) ? $clog2(N + 1) : 1;
  localparam int unsigned DW    = DIGIT + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic             c_q, c_nxt;
  logic             sub_q, sub_nxt;
  logic [WIDTH-1:0] s_q, s_nxt;
  logic             co_q, co_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;

  logic             op_c;
  logic [DW-1:0]    digit_sum_c;
  logic [WIDTH-1:0] s_shift_c;

  // Mode select; the add-only build ties subtract off.
`ifdef SUM_SUB_EN
  always_comb op_c = op;
`else
  always_comb op_c = 1'b0;
`endif

  // One digit of the sum, including the carry held over from the previous digit.
  always_comb begin
    digit_sum_c = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(c_q);
  end

  // The new digit enters at the MSB end, so after N shifts the LSB digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_full
    always_comb s_shift_c = digit_sum_c[DIGIT-1:0];
  end else begin : g_part
    always_comb s_shift_c = {digit_sum_c[DIGIT-1:0], s_q[WIDTH-1:DIGIT]};
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    c_nxt     = c_q;
    sub_nxt   = sub_q;
    s_nxt     = s_q;
    co_nxt    = co_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction is computed as A + ~B + ~Ci, so the final carry is an inverted borrow.
          a_nxt     = A;
          b_nxt     = op_c ? ~B : B;
          c_nxt     = Ci ^ op_c;
          sub_nxt   = op_c;
          s_nxt     = '0;
          co_nxt    = 1'b0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_nxt   = s_shift_c;
        a_nxt   = a_q >> DIGIT;
        b_nxt   = b_q >> DIGIT;
        c_nxt   = digit_sum_c[DIGIT];
        cnt_nxt = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          co_nxt    = digit_sum_c[DIGIT] ^ sub_q;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      c_q     <= c_nxt;
      sub_q   <= sub_nxt;
      s_q     <= s_nxt;
      co_q    <= co_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Co   = co_q;

endmodule
